// File: rtl/alu64_reg.sv
// alu64_reg: LEGv8-style integer ALU with a registered result and flags.
// Ports: clk, reset (sync, high), in_valid, a, b, alu_control -> result, zero, negative, carry, overflow, out_valid.
module alu64_reg #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_control,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             out_valid
);

  localparam int SW = $clog2(WIDTH);
  localparam int M  = WIDTH - 1;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_LSL   = 4'b0100;
  localparam logic [3:0] OP_LSR   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b0111;
  localparam logic [3:0] OP_ASR   = 4'b1000;
  localparam logic [3:0] OP_SLT   = 4'b1001;
  localparam logic [3:0] OP_SLTU  = 4'b1010;
  localparam logic [3:0] OP_NOR   = 4'b1100;

  logic [SW-1:0]  shamt;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] dif;
  logic [WIDTH-1:0] r;
  logic           c;
  logic           v;
  logic           slt;
  logic           sltu;

  assign shamt = b[SW-1:0];

  // Wide adds keep the carry-out; subtract is a + ~b + 1 so
  // the top bit is NOT borrow, i.e. set when a >= b unsigned.
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

  assign slt  = $signed(a) < $signed(b);
  assign sltu = a < b;

  always_comb begin
    r = '0;
    c = 1'b0;
    v = 1'b0;
    case (alu_control)
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_ADD: begin
        r = sum[M:0];
        c = sum[WIDTH];
        v = (a[M] == b[M]) && (sum[M] != a[M]);
      end
      OP_XOR:   r = a ^ b;
      OP_LSL:   r = a << shamt;
      OP_LSR:   r = a >> shamt;
      OP_SUB: begin
        r = dif[M:0];
        c = dif[WIDTH];
        v = (a[M] != b[M]) && (dif[M] != a[M]);
      end
      OP_PASSB: r = b;
      OP_ASR:   r = $unsigned($signed(a) >>> shamt);
      OP_SLT:   r = {{(WIDTH-1){1'b0}}, slt};
      OP_SLTU:  r = {{(WIDTH-1){1'b0}}, sltu};
      OP_NOR:   r = ~(a | b);
      default:  r = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result    <= '0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result   <= r;
        zero     <= (r == '0);
        negative <= r[M];
        carry    <= c;
        overflow <= v;
      end
    end
  end

endmodule

// File: tb/tb_alu64_reg.sv
// tb_alu64_reg: directed vector table plus reset, sweep and hold sequences.
// Drives inputs on the falling edge and checks registered outputs there.
module tb_alu64_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [63:0] a;
  logic [63:0] b;
  logic [3:0]  alu_control;
  logic [63:0] result;
  logic        zero;
  logic        negative;
  logic        carry;
  logic        overflow;
  logic        out_valid;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  alu64_reg #(.WIDTH(64)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .a(a),
    .b(b),
    .alu_control(alu_control),
    .result(result),
    .zero(zero),
    .negative(negative),
    .carry(carry),
    .overflow(overflow),
    .out_valid(out_valid)
  );

  typedef struct {
    string       name;
    logic [3:0]  ctl;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] r;
    logic [3:0]  f; // {z, n, c, v}
  } vec_t;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MSB  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk_all(input string nm, input logic [63:0] er,
                         input logic [3:0] ef, input logic ev);
    chk({nm, ".result"}, result, er);
    chk({nm, ".flags"}, {59'd0, zero, negative, carry, overflow, out_valid},
        {59'd0, ef, ev});
  endtask

  initial begin
    vt.push_back('{"add_wrap",   4'b0010, ONES,  64'd1, 64'd0, 4'b1010});
    vt.push_back('{"add_ovf",    4'b0010, MAXP,  64'd1, MSB,   4'b0101});
    vt.push_back('{"add_minmin", 4'b0010, MSB,   MSB,   64'd0, 4'b1011});
    vt.push_back('{"sub_3_5",    4'b0110, 64'd3, 64'd5, ONES - 64'd1, 4'b0100});
    vt.push_back('{"sub_5_5",    4'b0110, 64'd5, 64'd5, 64'd0, 4'b1010});
    vt.push_back('{"sub_0_1",    4'b0110, 64'd0, 64'd1, ONES,  4'b0100});
    vt.push_back('{"sub_ovf",    4'b0110, MSB,   64'd1, MAXP,  4'b0011});
    vt.push_back('{"lsl_63",     4'b0100, 64'd1, 64'd63, MSB,  4'b0100});
    vt.push_back('{"lsl_0hi",    4'b0100, 64'h1234, 64'h40, 64'h1234, 4'b0000});
    vt.push_back('{"lsr_63",     4'b0101, MSB,   64'd63, 64'd1, 4'b0000});
    vt.push_back('{"lsr_hi",     4'b0101, 64'hF0, 64'h104, 64'h0F, 4'b0000});
    vt.push_back('{"asr_4",      4'b1000, MSB,   64'd4,
                   64'hF800_0000_0000_0000, 4'b0100});
    vt.push_back('{"asr_pos",    4'b1000, MAXP,  64'd62, 64'd1, 4'b0000});
    vt.push_back('{"slt",        4'b1001, ONES,  64'd0, 64'd1, 4'b0000});
    vt.push_back('{"sltu",       4'b1010, ONES,  64'd0, 64'd0, 4'b1000});
    vt.push_back('{"sltu_t",     4'b1010, 64'd0, ONES,  64'd1, 4'b0000});
    vt.push_back('{"or",         4'b0001, 64'hF0, 64'h0F, 64'hFF, 4'b0000});
    vt.push_back('{"xor",        4'b0011, 64'hFF, 64'h0F, 64'hF0, 4'b0000});
    vt.push_back('{"nor",        4'b1100, 64'd0, 64'd0, ONES,  4'b0100});
    vt.push_back('{"passb",      4'b0111, ONES,  64'h1234, 64'h1234, 4'b0000});
    vt.push_back('{"op1111",     4'b1111, 64'd5, 64'd3, 64'd0, 4'b1000});
    vt.push_back('{"op1011",     4'b1011, ONES,  ONES,  64'd0, 4'b1000});

    reset = 1'b1;
    in_valid = 1'b1;
    a = 64'd5;
    b = 64'd3;
    alu_control = 4'b0010;

    // reset held two cycles with an issue pending
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk_all($sformatf("reset%0d", i), 64'd0, 4'b0000, 1'b0);
    end
    reset = 1'b0;
    @(negedge clk);
    chk_all("post_reset", 64'd8, 4'b0000, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);

    // AND sweep, back-to-back issue
    for (int k = 0; k <= 1024; k++) begin
      if (k > 0) begin
        logic [63:0] e;
        e = 64'((k - 1) / 32) & 64'((k - 1) % 32);
        chk_all($sformatf("and_%0d_%0d", (k - 1) / 32, (k - 1) % 32),
                e, {e == 64'd0, 3'b000}, 1'b1);
      end
      if (k < 1024) begin
        in_valid = 1'b1;
        alu_control = 4'b0000;
        a = 64'(k / 32);
        b = 64'(k % 32);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end

    // directed vector table
    foreach (vt[i]) begin
      in_valid = 1'b1;
      alu_control = vt[i].ctl;
      a = vt[i].a;
      b = vt[i].b;
      @(negedge clk);
      in_valid = 1'b0;
      chk_all(vt[i].name, vt[i].r, vt[i].f, 1'b1);
    end

    // hold: result persists while idle
    in_valid = 1'b1;
    alu_control = 4'b0010;
    a = 64'd2;
    b = 64'd2;
    @(negedge clk);
    chk_all("hold_issue", 64'd4, 4'b0000, 1'b1);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = 64'(i * 7 + 9);
      b = ONES;
      alu_control = 4'b0110;
      @(negedge clk);
      chk_all($sformatf("hold%0d", i), 64'd4, 4'b0000, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu64_reg.md
Name: alu64_reg

Overview:
- 64-bit integer ALU for the single-cycle processor datapath, LEGv8-style opcode encoding.
- Computes a combinational result from two operands and a 4-bit control code.
- Registers the result and the condition flags (Z, N, C, V) once per accepted operation, so outputs appear one clock after issue.
- Feeds the CBZ/branch logic (zero) and the register-file write-back path (result).

Parameters:
- WIDTH, 64, operand/result width in bits; shift amount uses the low log2(WIDTH) bits of b.

Ports:
- clk  input  1  system clock, all state updates on the rising edge
- reset  input  1  synchronous, active-high; clears all registered outputs
- in_valid  input  1  issue strobe; operands and control are sampled when high
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- alu_control  input  4  operation select (table below)
- result  output  WIDTH  registered result
- zero  output  1  registered: result == 0
- negative  output  1  registered: result[WIDTH-1]
- carry  output  1  registered carry flag (ADD/SUB only)
- overflow  output  1  registered signed-overflow flag (ADD/SUB only)
- out_valid  output  1  high for one cycle after each accepted operation

Behaviour:
- Reset, synchronous and active-high: result=0, zero=0, negative=0, carry=0, overflow=0, out_valid=0. Reset wins over a simultaneous in_valid; an operation issued in a reset cycle is discarded.
- Latency: one cycle. Operands issued with in_valid=1 at edge N produce outputs valid after edge N+1, with out_valid=1 in that cycle. Throughput is one operation per cycle; back-to-back issue is allowed.
- in_valid=0: result and flags hold their previous values, and out_valid=0 on the next cycle.
- Opcodes:
  - 0000 AND: a & b
  - 0001 OR: a | b
  - 0010 ADD: a + b
  - 0011 XOR: a ^ b
  - 0100 LSL: a << b[5:0]
  - 0101 LSR: logical a >> b[5:0]
  - 0110 SUB: a - b
  - 0111 PASSB: b
  - 1000 ASR: arithmetic a >>> b[5:0]
  - 1001 SLT: signed a<b, result 1 or 0
  - 1010 SLTU: unsigned a<b, result 1 or 0
  - 1100 NOR: ~(a | b)
  - 1011, 1101, 1110, 1111: result 0, all flags computed from that 0 (so zero=1)
- Arithmetic wraps modulo 2^WIDTH.
- Shift amounts of 0 return a unchanged. Shift amount 63 is legal. Upper bits of b beyond [5:0] are ignored for shifts.
- Flags:
  - zero = (result == 0) for every opcode.
  - negative = result MSB for every opcode.
  - carry:
    - ADD: carry-out of bit 63.
    - SUB: NOT borrow, i.e. 1 when a >= b unsigned (ARM convention).
    - All other opcodes: 0.
  - overflow:
    - ADD: operands have the same sign and the result sign differs.
    - SUB: operands have different signs and the result sign differs from a.
    - All other opcodes: 0.
- All outputs are driven only from registers; no combinational path from inputs to outputs.

Test Plan:
- Reset: assert reset 2 cycles with in_valid=1, a=5, b=3, control=0010 -> result=0, all flags 0, out_valid=0 throughout; first issue after deassert gives result=8 one cycle later.
- AND sweep: control=0000, a=i, b=j for all i,j in 0..31, issued back-to-back -> each result = i&j one cycle after issue. zero=1 exactly when i&j==0 (e.g. a=1, b=2 -> result 0, zero=1). out_valid=1 every cycle.
- ADD/SUB flags:
  - ADD 0xFFFF_FFFF_FFFF_FFFF + 1 -> result 0, zero=1, carry=1, overflow=0.
  - ADD 0x7FFF_FFFF_FFFF_FFFF + 1 -> result 0x8000_0000_0000_0000, negative=1, overflow=1, carry=0.
  - SUB 3-5 -> result 0xFFFF_FFFF_FFFF_FFFE, carry=0, negative=1.
  - SUB 5-5 -> result 0, zero=1, carry=1.
- Shifts/compare:
  - LSL 1 by 63 -> 0x8000_0000_0000_0000.
  - LSR 0x8000_0000_0000_0000 by 63 -> 1.
  - ASR 0x8000_0000_0000_0000 by 4 -> 0xF800_0000_0000_0000.
  - SLT a=-1, b=0 -> 1.
  - SLTU a=-1, b=0 -> 0.
- Misc ops:
  - OR 0xF0 | 0x0F -> 0xFF.
  - XOR 0xFF ^ 0x0F -> 0xF0.
  - NOR 0 | 0 -> all ones, negative=1.
  - PASSB b=0x1234 -> 0x1234.
  - Opcode 1111 -> result 0, zero=1.
- Hold: issue ADD 2+2, then in_valid=0 for 3 cycles with changing a/b -> result stays 4, out_valid=0 after the first output cycle.
